// File: rtl/dff_univ_shift.sv
// Universal shift register: hold, shift right/left, parallel load, shift counter.
// Define SHREG_ROTATE_EN to make both shift modes rotate instead of serial fill.
module dff_univ_shift #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sir,
  input  logic             sil,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic             so_r,
  output logic             so_l,
  output logic [CW-1:0]    cnt,
  output logic             full
);

  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  logic             fill_r;
  logic             fill_l;
  logic [WIDTH-1:0] q_nx;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    cnt_inc;

`ifdef SHREG_ROTATE_EN
  logic unused_serial;
  assign unused_serial = sir ^ sil;
  assign fill_r = q[0];
  assign fill_l = q[WIDTH-1];
`else
  assign fill_r = sir;
  assign fill_l = sil;
`endif

  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;

  // next-state select by mode; shifts count up, load clears the count
  always_comb begin
    q_nx   = q;
    cnt_nx = cnt;
    unique case (mode)
      2'b00: begin
      end
      2'b01: begin
        q_nx   = {fill_r, q[WIDTH-1:1]};
        cnt_nx = cnt_inc;
      end
      2'b10: begin
        q_nx   = {q[WIDTH-2:0], fill_l};
        cnt_nx = cnt_inc;
      end
      2'b11: begin
        q_nx   = d;
        cnt_nx = '0;
      end
    endcase
  end

  // state register: reset wins, then enable gates every update
  always_ff @(posedge c) begin
    if (r) begin
      q   <= '0;
      cnt <= '0;
    end else if (en) begin
      q   <= q_nx;
      cnt <= cnt_nx;
    end
  end

  assign q_b  = ~q;
  assign so_r = q[0];
  assign so_l = q[WIDTH-1];
  assign full = (cnt == CMAX);

endmodule

// File: doc/dff_univ_shift.md
DFF_UNIV_SHIFT -- requirements
Module: dff_univ_shift

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits; legal range is 2 or more.
REQ-002 Derived localparam: CW = clog2(WIDTH+1), the counter width.
REQ-003 c  input  1  clock; all state changes on its rising edge; this block has one clock.
REQ-004 r  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  clock enable.
REQ-006 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sir  input  1  serial input for right shift; enters the MSB.
REQ-009 sil  input  1  serial input for left shift; enters the LSB.
REQ-010 q  output  WIDTH  register contents.
REQ-011 q_b  output  WIDTH  bitwise complement of q.
REQ-012 so_r  output  1  equals q[0], the bit leaving on the next right shift.
REQ-013 so_l  output  1  equals q[WIDTH-1], the bit leaving on the next left shift.
REQ-014 cnt  output  CW  shifts performed since the last load or reset; saturates at WIDTH.
REQ-015 full  output  1  high when cnt == WIDTH.

Function
REQ-016 Edge priority SHALL be: r, then en low (hold everything), then mode.
REQ-017 mode 11 SHALL set q <= d and cnt <= 0.
REQ-018 mode 01 SHALL set q <= {sir, q[WIDTH-1:1]} and increment cnt.
REQ-019 mode 10 SHALL set q <= {q[WIDTH-2:0], sil} and increment cnt.
REQ-020 mode 00 SHALL hold q and cnt.
REQ-021 cnt SHALL saturate at WIDTH; further shifts SHALL still move q and leave cnt at WIDTH.
REQ-022 Latency: q and cnt SHALL update at the same edge that samples the inputs; there is no pipeline stage.
REQ-023 q_b, so_r, so_l and full SHALL be combinational functions of the registered q and cnt, with no glitch-prone input paths.
REQ-024 With en low, the block SHALL ignore d, sir, sil and mode completely, including the cnt update.
REQ-025 A direction change mid-sequence (01 followed by 10) SHALL keep counting from the current cnt; only a load or reset clears cnt.

Reset
REQ-026 With r high at an edge, the block SHALL set q = 0 and cnt = 0, regardless of en and mode.
REQ-027 After reset: q_b = all ones, so_r = 0, so_l = 0, full = 0.
REQ-028 Reset asserted mid-sequence SHALL discard the in-flight shift or load of that edge.
REQ-029 The block SHALL have no asynchronous path from r.

Configuration
REQ-030 Macro SHREG_ROTATE_EN.
REQ-031 When SHREG_ROTATE_EN is defined, shift modes SHALL rotate: right sets q <= {q[0], q[WIDTH-1:1]}, left sets q <= {q[WIDTH-2:0], q[WIDTH-1]}; sir and sil are ignored; the port list is unchanged.
REQ-032 When SHREG_ROTATE_EN is undefined, shift modes SHALL fill from sir and sil as in REQ-018 and REQ-019.
REQ-033 cnt and full behaviour SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-034 Reset: r=1 for 2 edges, with any mode/en -> q=00, q_b=FF, cnt=0, full=0, so_r=0, so_l=0.
REQ-035 Load: en=1, mode=11, d=A5, one edge -> q=A5, q_b=5A, so_r=1, so_l=1, cnt=0.
REQ-036 Right shift from A5: mode=01, sir=0, one edge -> q=52, cnt=1 (no macro); q=D2 (SHREG_ROTATE_EN).
REQ-037 Saturation, starting from A5: mode=10, sil=0, 9 edges -> after edge 8: q=00, cnt=8, full=1; after edge 9: cnt=8. With SHREG_ROTATE_EN: q=A5 after edge 8, then 4B after edge 9.
REQ-038 Enable and priority: en=0, mode=11, d=FF -> q and cnt unchanged. Then r=1, en=1, mode=11, d=FF on the same edge -> q=00, cnt=0.
